// File: rtl/rf_scan_pkg.sv
// rtl/rf_scan_pkg.sv - shared state and mode encodings for the register-file scan reader
package rf_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_ALL    = 1'b1;

endpackage

// File: rtl/rf_scan_reader_if.sv
// rtl/rf_scan_reader_if.sv - control, register-file read port and output stream of the scan reader
interface rf_scan_reader_if #(
  parameter int AWidth = 5,
  parameter int DWidth = 32
);

  logic              start;
  logic              mode;
  logic [AWidth-1:0] addr_in;
  logic              abort;
  logic [AWidth-1:0] rf_ra;
  logic [DWidth-1:0] rf_rd;
  logic              out_valid;
  logic              out_ready;
  logic [AWidth-1:0] out_addr;
  logic [DWidth-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  // master is the reader itself; slave is the debug unit / consumer side
  modport master (
    input  start, mode, addr_in, abort, rf_rd, out_ready,
    output rf_ra, out_valid, out_addr, out_data, out_last, busy, done
  );

  modport slave (
    output start, mode, addr_in, abort, rf_rd, out_ready,
    input  rf_ra, out_valid, out_addr, out_data, out_last, busy, done
  );

endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - CPU register file, x0 hardwired to zero, two write-first combinational read ports
module register_file #(
  parameter int AWidth = 5,
  parameter int DWidth = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWidth-1:0] wa,
  input  logic [DWidth-1:0] wd,
  input  logic [AWidth-1:0] ra1,
  output logic [DWidth-1:0] rd1,
  input  logic [AWidth-1:0] ra2,
  output logic [DWidth-1:0] rd2
);

  logic [DWidth-1:0] r_regs [1<<AWidth];

  always_ff @(posedge clk) begin
    if (we && (wa != '0)) begin
      r_regs[wa] <= wd;
    end
  end

  // a write landing in the same cycle is forwarded to the reader
  assign rd1 = (ra1 == '0) ? '0 : ((we && (wa == ra1)) ? wd : r_regs[ra1]);
  assign rd2 = (ra2 == '0) ? '0 : ((we && (wa == ra2)) ? wd : r_regs[ra2]);

endmodule

// File: rtl/rf_scan_reader.sv
// rtl/rf_scan_reader.sv - debug reader streaming one register or the whole file as addr-tagged words
module rf_scan_reader
  import rf_scan_pkg::*;
#(
  parameter int AWidth = 5,
  parameter int DWidth = 32
) (
  input logic                clk,
  input logic                rst,
  rf_scan_reader_if.master   bus
);

  localparam logic [AWidth-1:0] LastAddr = '1;

  state_t            r_state;
  state_t            w_next_state;
  logic [AWidth-1:0] r_cur_addr;
  logic              r_mode;
  logic              r_out_valid;
  logic [AWidth-1:0] r_out_addr;
  logic [DWidth-1:0] r_out_data;
  logic              r_out_last;
  logic              w_handshake;
  logic              w_last_word;

  assign w_handshake = r_out_valid && bus.out_ready;
  assign w_last_word = (r_mode == MODE_SINGLE) || (r_cur_addr == LastAddr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // abort outranks a coincident handshake, so the word in flight is dropped
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next_state = bus.abort ? S_FIN : S_SEND;
      end
      S_SEND: begin
        if (bus.abort) begin
          w_next_state = S_FIN;
        end else if (w_handshake) begin
          w_next_state = r_out_last ? S_FIN : S_LOAD;
        end
      end
      S_FIN: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_addr  <= '0;
      r_mode      <= MODE_SINGLE;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cur_addr <= (bus.mode == MODE_ALL) ? '0 : bus.addr_in;
            r_mode     <= bus.mode;
          end
        end
        S_LOAD: begin
          if (bus.abort) begin
            r_out_valid <= 1'b0;
          end else begin
            r_out_data  <= bus.rf_rd;
            r_out_addr  <= r_cur_addr;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last_word;
          end
        end
        S_SEND: begin
          if (bus.abort) begin
            r_out_valid <= 1'b0;
          end else if (w_handshake) begin
            r_out_valid <= 1'b0;
            if (!r_out_last) begin
              r_cur_addr <= r_cur_addr + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rf_ra     = (r_state == S_IDLE) ? '0 : r_cur_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_FIN);

endmodule
